branch_pred_pc: RTL and testbench

- Parametrised successor to the fetch-stage PC selector.
- Adds a dynamic conditional-branch predictor: a pattern history table (PHT) of saturating counters, with static, bimodal or gshare indexing, trained non-speculatively from the M stage.
- Produces the predicted next PC and the final fetch PC, including mispredict and ret redirects.
- Sits between the F pipeline register and fetch logic, with 32-bit saturating branch and mispredict statistics counters.

---
 rtl/branch_pred_pc_if.sv | 46 ++++
 rtl/branch_pred_pc.sv | 120 ++++++++++++
 tb/tb_branch_pred_pc.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_pred_pc_if.sv
// Signal bundle between the fetch stage, the M/W resolve paths and the branch predictor / PC selector.
interface branch_pred_pc_if #(
  parameter int IDX_W = 6
);
  logic [63:0]      f_predPC_i;
  logic [3:0]       f_icode_i;
  logic [3:0]       f_ifun_i;
  logic [63:0]      f_pc_i;
  logic [63:0]      f_valC_i;
  logic [63:0]      f_valP_i;
  logic             f_stall_i;
  logic [63:0]      pred_pc_o;
  logic             pred_taken_o;
  logic [IDX_W-1:0] pht_idx_o;

  logic [3:0]       M_icode_i;
  logic [3:0]       M_ifun_i;
  logic             M_Cnd_i;
  logic             M_branch_taken_i;
  logic [IDX_W-1:0] M_pht_idx_i;
  logic [63:0]      M_valA_i;
  logic [63:0]      M_valE_i;
  logic             M_upd_en_i;

  logic [3:0]       W_icode_i;
  logic [63:0]      W_valM_i;

  logic [63:0]      f_PC_o;
  logic             mispredict_o;
  logic [31:0]      br_cnt_o;
  logic [31:0]      mis_cnt_o;

  modport master (
    output f_predPC_i, f_icode_i, f_ifun_i, f_pc_i, f_valC_i, f_valP_i, f_stall_i,
    output M_icode_i, M_ifun_i, M_Cnd_i, M_branch_taken_i, M_pht_idx_i,
    output M_valA_i, M_valE_i, M_upd_en_i, W_icode_i, W_valM_i,
    input  pred_pc_o, pred_taken_o, pht_idx_o, f_PC_o, mispredict_o, br_cnt_o, mis_cnt_o
  );

  modport slave (
    input  f_predPC_i, f_icode_i, f_ifun_i, f_pc_i, f_valC_i, f_valP_i, f_stall_i,
    input  M_icode_i, M_ifun_i, M_Cnd_i, M_branch_taken_i, M_pht_idx_i,
    input  M_valA_i, M_valE_i, M_upd_en_i, W_icode_i, W_valM_i,
    output pred_pc_o, pred_taken_o, pht_idx_o, f_PC_o, mispredict_o, br_cnt_o, mis_cnt_o
  );
endinterface

// File: rtl/branch_pred_pc.sv
// Fetch-stage PC selector with a saturating-counter pattern history table (static, bimodal or gshare),
// trained non-speculatively from M, plus saturating branch/mispredict statistics.
module branch_pred_pc #(
  parameter int IDX_W    = 6,
  parameter int CNT_W    = 2,
  parameter int CNT_INIT = 1,
  parameter int MODE     = 1
) (
  input logic             clk_i,
  input logic             rst_n_i,
  branch_pred_pc_if.slave bus
);
  localparam logic [3:0]       IJXX    = 4'h7;
  localparam logic [3:0]       ICALL   = 4'h8;
  localparam logic [3:0]       IRET    = 4'h9;
  localparam int               N_ENT   = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INIT);

  logic [CNT_W-1:0] pht_q [N_ENT];
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_d;
  logic [31:0]      brCnt_q;
  logic [31:0]      brCnt_d;
  logic [31:0]      misCnt_q;
  logic [31:0]      misCnt_d;

  logic [IDX_W-1:0] fetchIdx;
  logic             predTaken;
  logic             isCall;
  logic             updValid;
  logic             mispredict;
  logic [CNT_W-1:0] updOld;
  logic [CNT_W-1:0] updNew;
  logic             unusedInputs;

  assign unusedInputs = ^{bus.f_stall_i, bus.M_ifun_i, bus.f_pc_i[63:IDX_W]};

  always_comb begin
    fetchIdx = '0;
    if (MODE == 1) begin
      fetchIdx = bus.f_pc_i[IDX_W-1:0];
    end else if (MODE == 2) begin
      fetchIdx = bus.f_pc_i[IDX_W-1:0] ^ ghr_q;
    end
  end

  // Unconditional jmp is always taken; conditional jumps consult the table unless the mode is static.
  always_comb begin
    predTaken = 1'b0;
    isCall    = (bus.f_icode_i == ICALL);
    if (bus.f_icode_i == IJXX) begin
      if ((bus.f_ifun_i == 4'h0) || (MODE == 0)) begin
        predTaken = 1'b1;
      end else begin
        predTaken = pht_q[fetchIdx][CNT_W-1];
      end
    end
  end

  assign bus.pred_taken_o = predTaken;
  assign bus.pht_idx_o    = fetchIdx;
  assign bus.pred_pc_o    = (predTaken || isCall) ? bus.f_valC_i : bus.f_valP_i;

  assign updValid         = (bus.M_icode_i == IJXX) && bus.M_upd_en_i;
  assign mispredict       = updValid && (bus.M_Cnd_i ^ bus.M_branch_taken_i);
  assign bus.mispredict_o = mispredict;

  // A mispredict recovery outranks a pending return in W.
  always_comb begin
    bus.f_PC_o = bus.f_predPC_i;
    if (mispredict) begin
      bus.f_PC_o = bus.M_branch_taken_i ? bus.M_valA_i : bus.M_valE_i;
    end else if (bus.W_icode_i == IRET) begin
      bus.f_PC_o = bus.W_valM_i;
    end
  end

  always_comb begin
    updOld   = pht_q[bus.M_pht_idx_i];
    updNew   = updOld;
    ghr_d    = ghr_q;
    brCnt_d  = brCnt_q;
    misCnt_d = misCnt_q;
    if (updValid) begin
      if (bus.M_Cnd_i) begin
        if (updOld != CNT_MAX) updNew = updOld + CNT_W'(1);
      end else begin
        if (updOld != '0) updNew = updOld - CNT_W'(1);
      end
      ghr_d = {ghr_q[IDX_W-2:0], bus.M_Cnd_i};
      if (brCnt_q != 32'hFFFF_FFFF) brCnt_d = brCnt_q + 32'd1;
      if (mispredict && (misCnt_q != 32'hFFFF_FFFF)) misCnt_d = misCnt_q + 32'd1;
    end
  end

  // Lookups see the pre-update table; the write lands on the entry that produced the prediction.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N_ENT; i++) begin
        pht_q[i] <= CNT_RST;
      end
      ghr_q    <= '0;
      brCnt_q  <= '0;
      misCnt_q <= '0;
    end else begin
      if (updValid && (MODE != 0)) begin
        pht_q[bus.M_pht_idx_i] <= updNew;
      end
      if (MODE == 2) begin
        ghr_q <= ghr_d;
      end
      brCnt_q  <= brCnt_d;
      misCnt_q <= misCnt_d;
    end
  end

  assign bus.br_cnt_o  = brCnt_q;
  assign bus.mis_cnt_o = misCnt_q;
endmodule

// File: tb/tb_branch_pred_pc.sv
// Bench for branch_pred_pc: a bimodal instance (IDX_W=6) and a gshare instance (IDX_W=4) share stimulus
// and are compared against a counter-array model after directed scenarios and a randomized run.
module tb_branch_pred_pc;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;
  localparam logic [3:0] INOP  = 4'h1;

  logic clk_i = 1'b0;
  logic rstN;
  always #5 clk_i = ~clk_i;

  branch_pred_pc_if #(.IDX_W(6)) busB ();
  branch_pred_pc_if #(.IDX_W(4)) busG ();

  branch_pred_pc #(.IDX_W(6), .CNT_W(2), .CNT_INIT(1), .MODE(1)) dutB (
    .clk_i(clk_i), .rst_n_i(rstN), .bus(busB)
  );
  branch_pred_pc #(.IDX_W(4), .CNT_W(2), .CNT_INIT(1), .MODE(2)) dutG (
    .clk_i(clk_i), .rst_n_i(rstN), .bus(busG)
  );

  logic [63:0] fPredPC, fPc, fValC, fValP, mValA, mValE, wValM;
  logic [3:0]  fIcode, fIfun, mIcode, mIfun, wIcode;
  logic        fStall, mCnd, mTaken, mUpdEn;
  logic [5:0]  mIdxB;
  logic [3:0]  mIdxG;

  int checks = 0;
  int errors = 0;

  // Model state: k=0 bimodal, k=1 gshare; counters kept as plain integers 0..3
  int     pht [2][64];
  int     ghr;
  longint brM [2];
  longint misM [2];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    busB.f_predPC_i = fPredPC;  busG.f_predPC_i = fPredPC;
    busB.f_icode_i  = fIcode;   busG.f_icode_i  = fIcode;
    busB.f_ifun_i   = fIfun;    busG.f_ifun_i   = fIfun;
    busB.f_pc_i     = fPc;      busG.f_pc_i     = fPc;
    busB.f_valC_i   = fValC;    busG.f_valC_i   = fValC;
    busB.f_valP_i   = fValP;    busG.f_valP_i   = fValP;
    busB.f_stall_i  = fStall;   busG.f_stall_i  = fStall;
    busB.M_icode_i  = mIcode;   busG.M_icode_i  = mIcode;
    busB.M_ifun_i   = mIfun;    busG.M_ifun_i   = mIfun;
    busB.M_Cnd_i    = mCnd;     busG.M_Cnd_i    = mCnd;
    busB.M_branch_taken_i = mTaken;
    busG.M_branch_taken_i = mTaken;
    busB.M_pht_idx_i = mIdxB;   busG.M_pht_idx_i = mIdxG;
    busB.M_valA_i   = mValA;    busG.M_valA_i   = mValA;
    busB.M_valE_i   = mValE;    busG.M_valE_i   = mValE;
    busB.M_upd_en_i = mUpdEn;   busG.M_upd_en_i = mUpdEn;
    busB.W_icode_i  = wIcode;   busG.W_icode_i  = wIcode;
    busB.W_valM_i   = wValM;    busG.W_valM_i   = wValM;
    #1;
  endtask

  task automatic setFetch(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] pc,
                          input logic [63:0] valC, input logic [63:0] valP);
    fIcode = icode; fIfun = ifun; fPc = pc; fValC = valC; fValP = valP; fPredPC = pc;
  endtask

  task automatic setResolve(input logic [3:0] icode, input logic cnd, input logic taken, input logic upd,
                            input int idx, input logic [63:0] valA, input logic [63:0] valE);
    mIcode = icode; mIfun = 4'h4; mCnd = cnd; mTaken = taken; mUpdEn = upd;
    mIdxB = 6'(idx); mIdxG = 4'(idx); mValA = valA; mValE = valE;
  endtask

  function automatic int modelIdx(input int k);
    if (k == 0) return int'(fPc[5:0]);
    return int'(fPc[3:0]) ^ ghr;
  endfunction

  function automatic logic modelTaken(input int k);
    if (fIcode != IJXX) return 1'b0;
    if (fIfun == 4'h0) return 1'b1;
    return (pht[k][modelIdx(k)] >= 2);
  endfunction

  function automatic logic modelMisp();
    return (mIcode == IJXX) && mUpdEn && (mCnd != mTaken);
  endfunction

  function automatic logic [63:0] modelFetchPc();
    if (modelMisp()) return mTaken ? mValA : mValE;
    if (wIcode == IRET) return wValM;
    return fPredPC;
  endfunction

  function automatic logic [63:0] modelPredPc(input int k);
    return (modelTaken(k) || fIcode == ICALL) ? fValC : fValP;
  endfunction

  task automatic modelClock();
    if (!rstN) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 64; i++) pht[k][i] = 1;
        brM[k] = 0;
        misM[k] = 0;
      end
      ghr = 0;
    end else if (mIcode == IJXX && mUpdEn) begin
      for (int k = 0; k < 2; k++) begin
        int e;
        e = (k == 0) ? int'(mIdxB) : int'(mIdxG);
        if (mCnd) pht[k][e] = (pht[k][e] == 3) ? 3 : pht[k][e] + 1;
        else      pht[k][e] = (pht[k][e] == 0) ? 0 : pht[k][e] - 1;
        if (brM[k] < 64'hFFFF_FFFF) brM[k]++;
        if (mCnd != mTaken && misM[k] < 64'hFFFF_FFFF) misM[k]++;
      end
      ghr = ((ghr << 1) | int'(mCnd)) & 15;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    modelClock();
    @(negedge clk_i);
  endtask

  task automatic checkAll();
    checkOutput("B.pred_pc",    busB.pred_pc_o,          modelPredPc(0));
    checkOutput("B.pred_taken", 64'(busB.pred_taken_o),  64'(modelTaken(0)));
    checkOutput("B.pht_idx",    64'(busB.pht_idx_o),     64'(modelIdx(0)));
    checkOutput("B.f_PC",       busB.f_PC_o,             modelFetchPc());
    checkOutput("B.mispredict", 64'(busB.mispredict_o),  64'(modelMisp()));
    checkOutput("B.br_cnt",     64'(busB.br_cnt_o),      64'(brM[0]));
    checkOutput("B.mis_cnt",    64'(busB.mis_cnt_o),     64'(misM[0]));
    checkOutput("G.pred_pc",    busG.pred_pc_o,          modelPredPc(1));
    checkOutput("G.pred_taken", 64'(busG.pred_taken_o),  64'(modelTaken(1)));
    checkOutput("G.pht_idx",    64'(busG.pht_idx_o),     64'(modelIdx(1)));
    checkOutput("G.f_PC",       busG.f_PC_o,             modelFetchPc());
    checkOutput("G.mispredict", 64'(busG.mispredict_o),  64'(modelMisp()));
    checkOutput("G.br_cnt",     64'(busG.br_cnt_o),      64'(brM[1]));
    checkOutput("G.mis_cnt",    64'(busG.mis_cnt_o),     64'(misM[1]));
  endtask

  initial begin
    rstN = 1'b0; fStall = 1'b0; wIcode = INOP; wValM = 64'h0;
    setFetch(INOP, 4'h0, 64'h0, 64'h0, 64'h0);
    setResolve(INOP, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0);
    applyStimulus();
    tick();
    tick();
    rstN = 1'b1;

    $display("[TB] reset state and first bimodal fetch");
    setFetch(IJXX, 4'h4, 64'h40, 64'h100, 64'h49);
    applyStimulus();
    checkOutput("reset br_cnt", 64'(busB.br_cnt_o), 64'h0);
    checkOutput("reset mis_cnt", 64'(busB.mis_cnt_o), 64'h0);
    checkOutput("jne@40 pred_taken", 64'(busB.pred_taken_o), 64'h0);
    checkOutput("jne@40 pred_pc", busB.pred_pc_o, 64'h49);
    checkOutput("jne@40 pht_idx", 64'(busB.pht_idx_o), 64'h0);
    checkAll();
    tick();

    $display("[TB] two taken resolves at idx 0 predicted not-taken");
    for (int n = 0; n < 2; n++) begin
      setResolve(IJXX, 1'b1, 1'b0, 1'b1, 0, 64'h49, 64'h100);
      applyStimulus();
      checkOutput("train0 mispredict", 64'(busB.mispredict_o), 64'h1);
      checkOutput("train0 f_PC", busB.f_PC_o, 64'h100);
      checkAll();
      tick();
    end
    setResolve(INOP, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0);
    applyStimulus();
    checkOutput("refetch@40 pred_taken", 64'(busB.pred_taken_o), 64'h1);
    checkOutput("refetch@40 pred_pc", busB.pred_pc_o, 64'h100);
    checkOutput("after train br_cnt", 64'(busB.br_cnt_o), 64'h2);
    checkOutput("after train mis_cnt", 64'(busB.mis_cnt_o), 64'h2);
    checkAll();

    $display("[TB] not-taken saturation at idx 5");
    rstN = 1'b0;
    applyStimulus();
    tick();
    rstN = 1'b1;
    for (int n = 0; n < 4; n++) begin
      setResolve(IJXX, 1'b0, 1'b0, 1'b1, 5, 64'h0, 64'h0);
      applyStimulus();
      checkAll();
      tick();
    end
    setResolve(INOP, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0);
    setFetch(IJXX, 4'h4, 64'h5, 64'h500, 64'h0E);
    applyStimulus();
    checkOutput("sat0 pred_taken", 64'(busB.pred_taken_o), 64'h0);
    setResolve(IJXX, 1'b1, 1'b0, 1'b1, 5, 64'h0E, 64'h500);
    applyStimulus();
    tick();
    setResolve(INOP, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0);
    applyStimulus();
    checkOutput("sat0+1 pred_taken", 64'(busB.pred_taken_o), 64'h0);
    setResolve(IJXX, 1'b1, 1'b0, 1'b1, 5, 64'h0E, 64'h500);
    applyStimulus();
    tick();
    setResolve(INOP, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0);
    applyStimulus();
    checkOutput("sat0+2 pred_taken", 64'(busB.pred_taken_o), 64'h1);
    checkAll();

    $display("[TB] f_PC priority");
    setResolve(IJXX, 1'b0, 1'b1, 1'b1, 0, 64'h88, 64'h300);
    wIcode = IRET; wValM = 64'h200;
    applyStimulus();
    checkOutput("misp over ret f_PC", busB.f_PC_o, 64'h88);
    checkAll();
    mUpdEn = 1'b0;
    applyStimulus();
    checkOutput("ret f_PC", busB.f_PC_o, 64'h200);
    wIcode = INOP;
    applyStimulus();
    checkOutput("default f_PC", busB.f_PC_o, 64'h5);
    checkAll();

    $display("[TB] gshare history");
    rstN = 1'b0;
    applyStimulus();
    tick();
    rstN = 1'b1;
    setResolve(IJXX, 1'b1, 1'b1, 1'b1, 2, 64'h0, 64'h0); applyStimulus(); tick();
    setResolve(IJXX, 1'b1, 1'b1, 1'b1, 2, 64'h0, 64'h0); applyStimulus(); tick();
    setResolve(IJXX, 1'b0, 1'b0, 1'b1, 2, 64'h0, 64'h0); applyStimulus(); tick();
    setResolve(INOP, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0);
    setFetch(IJXX, 4'h2, 64'h03, 64'h700, 64'h0C);
    applyStimulus();
    checkOutput("gshare pht_idx", 64'(busG.pht_idx_o), 64'h5);
    checkOutput("gshare br_cnt", 64'(busG.br_cnt_o), 64'h3);
    checkAll();
    setFetch(ICALL, 4'h0, 64'h20, 64'h900, 64'h29);
    applyStimulus();
    checkOutput("call pred_pc", busB.pred_pc_o, 64'h900);
    checkOutput("call pred_taken", 64'(busB.pred_taken_o), 64'h0);
    checkAll();

    $display("[TB] mispredict counter saturation and reset");
    setFetch(IJXX, 4'h4, 64'h40, 64'h100, 64'h49);
    setResolve(IJXX, 1'b1, 1'b0, 1'b1, 0, 64'h49, 64'h100);
    force dutB.misCnt_q = 32'hFFFF_FFFE;
    misM[0] = 64'hFFFF_FFFE;
    applyStimulus();
    tick();
    release dutB.misCnt_q;
    tick();
    tick();
    setResolve(INOP, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0);
    applyStimulus();
    checkOutput("mis_cnt saturated", 64'(busB.mis_cnt_o), 64'hFFFF_FFFF);
    checkOutput("pre-reset pred_taken", 64'(busB.pred_taken_o), 64'h1);
    checkAll();
    rstN = 1'b0;
    applyStimulus();
    tick();
    rstN = 1'b1;
    applyStimulus();
    checkOutput("post-reset mis_cnt", 64'(busB.mis_cnt_o), 64'h0);
    checkOutput("post-reset br_cnt", 64'(busB.br_cnt_o), 64'h0);
    checkOutput("post-reset pred_taken", 64'(busB.pred_taken_o), 64'h0);
    checkAll();

    $display("[TB] randomized run");
    for (int n = 0; n < 400; n++) begin
      rstN    = ($urandom_range(0, 99) != 0);
      fIcode  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : IJXX;
      fIfun   = 4'($urandom_range(0, 6));
      fPc     = {$urandom, 29'($urandom), 3'($urandom_range(0, 7))};
      fValC   = {$urandom, $urandom};
      fValP   = {$urandom, $urandom};
      fPredPC = {$urandom, $urandom};
      fStall  = 1'($urandom_range(0, 1));
      mIcode  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : IJXX;
      mIfun   = 4'($urandom_range(0, 6));
      mCnd    = 1'($urandom_range(0, 1));
      mTaken  = 1'($urandom_range(0, 1));
      mUpdEn  = ($urandom_range(0, 4) != 0);
      mIdxB   = 6'($urandom_range(0, 7));
      mIdxG   = 4'($urandom_range(0, 15));
      mValA   = {$urandom, $urandom};
      mValE   = {$urandom, $urandom};
      wIcode  = ($urandom_range(0, 3) == 0) ? IRET : 4'($urandom_range(0, 15));
      wValM   = {$urandom, $urandom};
      applyStimulus();
      checkAll();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
